// File: rtl/srt_pkg.sv
// Shared definitions for the radix-4 SRT divider and its quotient collection logic.
package srt_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam int DW = 3;
  localparam logic signed [DW-1:0] QD_MIN = -3'sd2;
  localparam logic signed [DW-1:0] QD_MAX = 3'sd2;
endpackage

// File: rtl/otf_conv_step.sv
// One radix-4 on-the-fly conversion step: appends a signed digit to Q and QM.
module otf_conv_step
  import srt_pkg::*;
#(
  parameter int QW = 54
) (
  input  logic [QW-1:0] q_cur,
  input  logic [QW-1:0] qm_cur,
  input  logic [DW-1:0] digit,
  output logic [QW-1:0] q_next,
  output logic [QW-1:0] qm_next,
  output logic          illegal
);
  logic [DW-1:0] d_eff;
  logic          pos;
  logic [1:0]    lo_q;
  logic [1:0]    lo_m;

  always_comb begin
    illegal = (signed'(digit) > QD_MAX) || (signed'(digit) < QD_MIN);
    d_eff   = illegal ? '0 : digit;
    pos     = !d_eff[DW-1] && (d_eff != '0);
    // (4+q) and q share the low two bits, as do (3+q) and (q-1)
    lo_q    = d_eff[1:0];
    lo_m    = d_eff[1:0] - 2'd1;
    q_next  = d_eff[DW-1] ? {qm_cur[QW-3:0], lo_q} : {q_cur[QW-3:0], lo_q};
    qm_next = pos ? {q_cur[QW-3:0], lo_m} : {qm_cur[QW-3:0], lo_m};
  end
endmodule

// File: rtl/quotient_otf_reg.sv
// Collects NDIGITS radix-4 quotient digits, converts on the fly, and presents
// the sign-corrected quotient on a valid/ready port.
module quotient_otf_reg
  import srt_pkg::*;
#(
  parameter  int NDIGITS = 27,
  localparam int QW      = 2*NDIGITS,
  localparam int CW      = $clog2(NDIGITS+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_digit,
  input  logic          rem_neg,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [QW-1:0] quotient,
  output logic          busy,
  output logic [CW-1:0] digit_count,
  output logic          err
);
  localparam logic [CW-1:0] LAST = CW'(NDIGITS-1);

  state_t        state;
  logic [QW-1:0] q, qm, q_next, qm_next;
  logic [CW-1:0] cnt;
  logic          illegal;

  otf_conv_step #(.QW(QW)) u_step (
    .q_cur   (q),
    .qm_cur  (qm),
    .digit   (in_digit),
    .q_next  (q_next),
    .qm_next (qm_next),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      qm        <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else if (start) begin
      // any pending HOLD transfer with out_ready still completes on this edge
      state     <= COLLECT;
      q         <= '0;
      qm        <= '1;
      cnt       <= '0;
      err       <= 1'b0;
      busy      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: if (in_valid) begin
          q   <= q_next;
          qm  <= qm_next;
          err <= err | illegal;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        IDLE:    ;
        default: state <= IDLE;
      endcase
    end
  end

  assign quotient    = out_valid ? (rem_neg ? qm : q) : '0;
  assign digit_count = cnt;
endmodule

// File: tb/tb_quotient_otf_reg.sv
// Scoreboarded directed test of quotient_otf_reg with NDIGITS=4.
module tb_quotient_otf_reg;
  localparam int ND = 4;
  localparam int QW = 2*ND;
  localparam int CW = $clog2(ND+1);

  logic          clk = 1'b0;
  logic          reset, start, in_valid, rem_neg, out_ready;
  logic [2:0]    in_digit;
  logic          out_valid, busy, err;
  logic [QW-1:0] quotient;
  logic [CW-1:0] digit_count;

  typedef struct packed {
    logic [QW-1:0] quo;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  quotient_otf_reg #(.NDIGITS(ND)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_digit    (in_digit),
    .rem_neg     (rem_neg),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .busy        (busy),
    .digit_count (digit_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  // monitor: compare every completed transfer against the scoreboard
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_unexpected: got quotient=%h err=%b, expected no transfer", quotient, err);
      end else begin
        e = exp_q.pop_front();
        if (quotient !== e.quo || err !== e.err) begin
          n_fail++;
          $display("FAIL xfer: got quotient=%h err=%b, expected quotient=%h err=%b",
                   quotient, err, e.quo, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] d);
    in_valid = 1'b1;
    in_digit = d;
    tick();
    in_valid = 1'b0;
    in_digit = 3'd0;
  endtask

  // handshake with the given rem_neg, expecting the monitor to see exp
  task automatic xfer(input logic rn, input logic [QW-1:0] quo, input logic e);
    rem_neg = rn;
    exp_q.push_back('{quo: quo, err: e});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rem_neg   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_count"},     32'(digit_count), 0);
    check({tag, "_err"},       32'(err), 0);
    check({tag, "_quotient"},  32'(quotient), 0);
  endtask

  task automatic run_basic(input string tag);
    do_start();
    check({tag, "_busy"}, 32'(busy), 1);
    send(3'sd1);
    send(3'sd2);
    send(-3'sd1);
    check({tag, "_not_yet_valid"}, 32'(out_valid), 0);
    send(3'sd0);
    check({tag, "_valid"},    32'(out_valid), 1);
    check({tag, "_err"},      32'(err), 0);
    check({tag, "_count"},    32'(digit_count), 4);
    check({tag, "_q_pos"},    32'(quotient), 32'h5C);
    xfer(1'b1, 8'h5B, 1'b0);
    check({tag, "_idle_valid"}, 32'(out_valid), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_digit = 3'd0;
    rem_neg = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_zero("reset");

    run_basic("basic");

    // QM must start at all ones for a leading negative digit
    do_start();
    send(-3'sd2); send(3'sd0); send(3'sd0); send(3'sd0);
    check("neg_q_pos", 32'(quotient), 32'h80);
    xfer(1'b1, 8'h7F, 1'b0);

    // illegal digit is processed as zero and sets a sticky err
    do_start();
    send(3'sd1);
    check("err_before", 32'(err), 0);
    send(3'b011);
    check("err_set", 32'(err), 1);
    send(3'sd1); send(3'sd1);
    check("err_hold", 32'(err), 1);
    check("ill_q", 32'(quotient), 32'h45);
    xfer(1'b0, 8'h45, 1'b1);
    do_start();
    check("err_cleared", 32'(err), 0);

    // backpressure in HOLD, stray digits must be ignored
    send(3'sd2); send(3'sd1); send(3'sd0); send(-3'sd2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_digit = 3'($urandom_range(0, 7));
      tick();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_q", 32'(quotient), 32'h8E);
      check("bp_count", 32'(digit_count), 4);
    end
    in_valid = 1'b0;
    xfer(1'b0, 8'h8E, 1'b0);
    check("bp_idle_valid", 32'(out_valid), 0);
    check("bp_idle_busy", 32'(busy), 0);

    // restart mid-division
    do_start();
    send(3'sd2); send(3'sd2);
    check("rs_count_before", 32'(digit_count), 2);
    do_start();
    check("rs_count_after", 32'(digit_count), 0);
    send(3'sd1); send(3'sd2); send(-3'sd1); send(3'sd0);
    check("rs_q", 32'(quotient), 32'h5C);
    // start together with out_ready: transfer completes, then COLLECT
    exp_q.push_back('{quo: 8'h5C, err: 1'b0});
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("rs_start_busy", 32'(busy), 1);
    check("rs_start_valid", 32'(out_valid), 0);

    // reset after three digits loses the partial result
    send(3'sd1); send(3'sd1); send(3'sd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midreset");

    run_basic("after_reset");

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/quotient_otf_reg.md
# quotient_otf_reg

Parametrised quotient-digit collector for the radix-4 SRT divider. It accepts one signed radix-4 quotient digit per cycle from the divider datapath and converts the digits to binary on the fly. It keeps the running quotient Q and its decrement QM so that no carry-propagate pass is needed at the end. After NDIGITS digits it presents the sign-corrected quotient on a valid/ready output port. It replaces the plain SIPO digit shift register between the SRT iteration stage and the result formatter.

## Interface
- NDIGITS, 27: quotient digits per division; must be ≥ 2.
- QW, 2*NDIGITS: quotient width in bits; derived, not overridable.
- CW, $clog2(NDIGITS+1): digit counter width; derived.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new division: clear state, enter COLLECT.
- in_valid  in  1  in_digit valid this cycle.
- in_digit  in  3  quotient digit, two's complement; legal range -2..+2.
- rem_neg  in  1  final partial remainder is negative; sampled only in HOLD.
- out_ready  in  1  consumer accepts quotient.
- out_valid  out  1  quotient available.
- quotient  out  QW  result: QM if rem_neg else Q; driven 0 when out_valid=0.
- busy  out  1  state is COLLECT.
- digit_count  out  CW  digits accepted in the current division.
- err  out  1  sticky: an illegal digit (+3, -3, -4) was received since the last start.

## Operation
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - in_valid ignored.
  - start → COLLECT.
- COLLECT: on each in_valid with digit q:
  - q ≥ 0: Q ← {Q[QW-3:0], q[1:0]}.
  - q < 0: Q ← {QM[QW-3:0], (4+q)[1:0]}.
  - q > 0: QM ← {Q[QW-3:0], (q-1)[1:0]}.
  - q ≤ 0: QM ← {QM[QW-3:0], (3+q)[1:0]}.
  - digit_count increments on each accepted digit.
  - When the NDIGITS-th digit is accepted → HOLD.
- Illegal digits (3'b011, 3'b101, 3'b100):
  - Set err.
  - Are processed as q=0.
  - Still count toward NDIGITS.
- HOLD:
  - out_valid=1.
  - Q, QM and digit_count are frozen.
  - in_valid is ignored.
  - out_valid & out_ready → IDLE.
- start (any state): Q ← 0, QM ← all ones (-1), digit_count ← 0, err ← 0, state ← COLLECT.
  - start has priority over in_valid; a digit presented in the start cycle is dropped.
  - start in HOLD together with out_ready: the transfer completes in that cycle, then the block enters COLLECT.
  - start in HOLD without out_ready: the result is discarded.
- reset: state IDLE, Q=0, QM=0, digit_count=0, err=0, out_valid=0, busy=0, quotient=0.

## Timing
- One digit per cycle at full rate; there is no input backpressure.
- out_valid rises the cycle after the edge that accepts the last digit.
  - Minimum start-to-out_valid: NDIGITS+1 edges.
- quotient is combinational from Q/QM and rem_neg while in HOLD.
  - rem_neg must be held stable until the handshake completes.
- The handshake completes on the edge where out_valid & out_ready are both 1.
  - out_valid falls on the following cycle, unless start was also asserted on that edge; then the block is in COLLECT.
- reset mid-COLLECT or mid-HOLD: all outputs are 0 on the next cycle and any partial result is lost.
- in_valid=0 cycles inside COLLECT stall conversion without loss.

## Structure
- Shared package srt_pkg holds:
  - the state enum (IDLE/COLLECT/HOLD);
  - the radix-4 digit width constant (3);
  - the legal digit bounds QD_MIN=-2 and QD_MAX=+2.
- One natural sub-module: otf_conv_step. It is combinational: (Q, QM, q) → (Q_next, QM_next, illegal). It is reused by the planned radix-4 square-root unit.
- Top level holds the FSM, digit counter, err flag and output mux.

## Test plan
- NDIGITS=4, start, then digits +1,+2,-1,0 back-to-back.
  - Expect out_valid on cycle 5 and err=0.
  - With rem_neg=0: quotient=8'h5C. With rem_neg=1: quotient=8'h5B.
- NDIGITS=4, digits -2,0,0,0.
  - Expect quotient=8'h80 (rem_neg=0) and 8'h7F (rem_neg=1); checks the QM=-1 initial load.
- NDIGITS=4, digits +1,3'b011,+1,+1.
  - Expect err=1 from the cycle after the illegal digit.
  - Expect quotient=8'h45 (illegal digit treated as 0).
  - err stays set through HOLD and clears on the next start.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while driving in_valid with random digits.
  - quotient and digit_count must stay constant and out_valid must stay 1.
  - Raise out_ready → IDLE on the next cycle, out_valid=0.
- Restart: start, digits +2,+2, then start again, then +1,+2,-1,0.
  - Expect digit_count=2 before the restart and 0 after it.
  - Expect final quotient=8'h5C.
- Reset mid-COLLECT after 3 digits, then a normal run.
  - After reset all outputs must be 0.
  - The next run must match the first scenario exactly.
